shift_seq8: RTL and testbench

- Sequential front end for the 8-bit combinational shifter `barrel_shifter8`. Contains exactly one instance of it.
- Accepts shift commands over a valid/ready handshake, registers the operands and drives the shifter.
- Implements rotate-left as two passes through the single shifter instance.
- Holds each result in an output register until the consumer accepts it. Sits between the datapath's operand source and its writeback.

---
 rtl/shift_seq8.sv | 146 ++++++++++++++
 tb/tb_shift_seq8.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq8.sv
// Sequential front end for the 8-bit combinational barrel shifter: valid/ready
// command intake, registered operands, two-pass rotate-left and a held result.

module barrel_shifter8 (
    input  logic [7:0] din_i,
    input  logic [2:0] shamt_i,
    input  logic       lr_i,
    input  logic       al_i,
    output logic [7:0] dout_o
);

    always_comb begin
        if (lr_i) begin
            dout_o = din_i << shamt_i;
        end else if (al_i) begin
            dout_o = 8'($signed(din_i) >>> shamt_i);
        end else begin
            dout_o = din_i >> shamt_i;
        end
    end

endmodule

module shift_seq8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [2:0] in_shamt,
    input  logic [1:0] in_op,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_zero,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        HOLD  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_e;

    state_e     state_q;
    op_e        op_q;
    logic [7:0] data_q;
    logic [2:0] shamt_q;
    logic [7:0] res_q;
    logic [7:0] tmp_q;

    logic       sh_lr;
    logic       sh_al;
    logic [2:0] sh_amt;
    logic [7:0] sh_dout;

    // Rotate-left is a left pass followed by a right pass of (8 - n) mod 8.
    always_comb begin
        sh_lr  = 1'b1;
        sh_al  = 1'b0;
        sh_amt = shamt_q;
        if (state_q == PASS2) begin
            sh_lr  = 1'b0;
            sh_amt = 3'd0 - shamt_q;
        end else begin
            unique case (op_q)
                OP_SLL: sh_lr = 1'b1;
                OP_SRL: sh_lr = 1'b0;
                OP_SRA: begin
                    sh_lr = 1'b0;
                    sh_al = 1'b1;
                end
                OP_ROL: sh_lr = 1'b1;
            endcase
        end
    end

    barrel_shifter8 u_shifter (
        .din_i   (data_q),
        .shamt_i (sh_amt),
        .lr_i    (sh_lr),
        .al_i    (sh_al),
        .dout_o  (sh_dout)
    );

    // NOTE: every state register, including the operand and result registers,
    // is cleared by the async reset and updated with non-blocking assignments
    // so no stale result can surface after a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_SLL;
            data_q  <= 8'h00;
            shamt_q <= 3'd0;
            res_q   <= 8'h00;
            tmp_q   <= 8'h00;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        shamt_q <= in_shamt;
                        op_q    <= op_e'(in_op);
                        state_q <= PASS1;
                    end
                end
                PASS1: begin
                    if (op_q != OP_ROL) begin
                        res_q   <= sh_dout;
                        state_q <= HOLD;
                    end else if (shamt_q == 3'd0) begin
                        res_q   <= data_q;
                        state_q <= HOLD;
                    end else begin
                        tmp_q   <= sh_dout;
                        state_q <= PASS2;
                    end
                end
                PASS2: begin
                    res_q   <= sh_dout | tmp_q;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign out_data  = res_q;
    assign out_zero  = (res_q == 8'h00);

endmodule

// File: tb/tb_shift_seq8.sv
// Directed self-checking bench for shift_seq8: latency, results, backpressure,
// back-to-back streaming and asynchronous reset during the second rotate pass.

module tb_shift_seq8;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_shamt;
    logic [1:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_zero;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROL = 2'b11;

    shift_seq8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, measure latency in cycles from the accepting cycle,
    // check the held result and optionally accept it.
    task automatic send(input string tag, input logic [1:0] op, input logic [7:0] d,
                        input logic [2:0] s, input logic [7:0] exp_d, input int exp_lat,
                        input bit release_out);
        int waited = 0;
        int edges  = 0;
        while (!in_ready && waited < 20) begin
            step();
            waited++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_shamt = s;
        step();
        in_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (!out_valid && edges < 10) begin
            step();
            edges++;
        end
        check({tag, "_lat"}, 32'(edges + 1), 32'(exp_lat));
        check({tag, "_data"}, 32'(out_data), 32'(exp_d));
        check({tag, "_zero"}, 32'(out_zero), 32'(exp_d == 8'h00));
        check({tag, "_inrdy_lo"}, 32'(in_ready), 32'd0);
        if (release_out) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check({tag, "_vld_done"}, 32'(out_valid), 32'd0);
            check({tag, "_inrdy_back"}, 32'(in_ready), 32'd1);
        end
    endtask

    logic [1:0] b_op   [3] = '{SRL, ROL, SLL};
    logic [7:0] b_data [3] = '{8'hF0, 8'h12, 8'h03};
    logic [2:0] b_sh   [3] = '{3'd4, 3'd4, 3'd2};
    logic [7:0] b_exp  [3] = '{8'h0F, 8'h21, 8'h0C};

    initial begin
        int sent;
        int got;
        int cyc;
        int xcyc [3];
        logic [7:0] xdat [3];
        logic acc;
        logic xf;
        logic [7:0] xd;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_shamt  = 3'd0;
        in_op     = 2'b00;
        out_ready = 1'b0;
        #23;
        rst_n = 1'b1;
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_out_zero", 32'(out_zero), 32'd1);

        send("sll_81_1", SLL, 8'h81, 3'd1, 8'h02, 2, 1'b1);
        send("srl_90_3", SRL, 8'h90, 3'd3, 8'h12, 2, 1'b1);
        send("sra_90_3", SRA, 8'h90, 3'd3, 8'hF2, 2, 1'b1);
        send("sra_70_7", SRA, 8'h70, 3'd7, 8'h00, 2, 1'b1);
        send("rol_81_1", ROL, 8'h81, 3'd1, 8'h03, 3, 1'b1);
        send("rol_a5_4", ROL, 8'hA5, 3'd4, 8'h5A, 3, 1'b1);
        send("rol_a5_0", ROL, 8'hA5, 3'd0, 8'hA5, 2, 1'b1);

        // Backpressure: result must hold while in_valid pulses are ignored.
        send("bp_sra_81_1", SRA, 8'h81, 3'd1, 8'hC0, 2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_op    = SLL;
            in_data  = 8'h55;
            in_shamt = 3'd1;
            step();
            check("bp_hold_data", 32'(out_data), 32'hC0);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_inrdy", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_xfer_done", 32'(out_valid), 32'd0);
        check("bp_xfer_inrdy", 32'(in_ready), 32'd1);
        step();
        check("bp_no_dup_valid", 32'(out_valid), 32'd0);
        check("bp_no_dup_busy", 32'(busy), 32'd0);

        // Back-to-back stream with out_ready tied high.
        sent = 0;
        got  = 0;
        cyc  = 0;
        in_op     = b_op[0];
        in_data   = b_data[0];
        in_shamt  = b_sh[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (got < 3 && cyc < 40) begin
            acc = in_valid && in_ready;
            xf  = out_valid && out_ready;
            xd  = out_data;
            step();
            cyc++;
            if (xf) begin
                xdat[got] = xd;
                xcyc[got] = cyc;
                got++;
            end
            if (acc) begin
                sent++;
                if (sent < 3) begin
                    in_op    = b_op[sent];
                    in_data  = b_data[sent];
                    in_shamt = b_sh[sent];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("b2b_count", 32'(got), 32'd3);
        if (got == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("b2b_data%0d", i), 32'(xdat[i]), 32'(b_exp[i]));
            end
            check("b2b_gap_rol", 32'(xcyc[1] - xcyc[0]), 32'd4);
            check("b2b_gap_sll", 32'(xcyc[2] - xcyc[1]), 32'd3);
        end
        step();
        out_ready = 1'b0;
        check("b2b_idle_after", 32'(out_valid), 32'd0);
        check("b2b_busy_after", 32'(busy), 32'd0);

        // Asynchronous reset during PASS2 of a nonzero rotate.
        in_valid = 1'b1;
        in_op    = ROL;
        in_data  = 8'hFF;
        in_shamt = 3'd3;
        step();
        in_valid = 1'b0;
        step();
        check("rstmid_busy_pre", 32'(busy), 32'd1);
        check("rstmid_valid_pre", 32'(out_valid), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", 32'(out_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_data", 32'(out_data), 32'h00);
        check("rstmid_zero", 32'(out_zero), 32'd1);
        step();
        step();
        #2;
        rst_n = 1'b1;
        step();
        check("rstrel_inrdy", 32'(in_ready), 32'd1);
        check("rstrel_valid", 32'(out_valid), 32'd0);
        step();
        check("rstrel_no_stale", 32'(out_valid), 32'd0);

        send("sll_01_7", SLL, 8'h01, 3'd7, 8'h80, 2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
